// File: rtl/fetch_bundle_packer_pkg.sv
// Shared fetch constants: instruction width, issue width, NOP encoding and pad word.
// Build option: define PACKER_NOP_PAD_EN to pad short bundles with NOP (addi x0,x0,0)
// instead of all-zero words.
package fetch_bundle_packer_pkg;

  localparam int unsigned INSN_LEN    = 32;
  localparam int unsigned ISSUE_WIDTH = 4;
  localparam int unsigned CNT_W       = 3;

  localparam logic [INSN_LEN-1:0] NOP_INSN = 32'h0000_0013;

`ifdef PACKER_NOP_PAD_EN
  localparam logic [INSN_LEN-1:0] PAD_INSN = NOP_INSN;
`else
  localparam logic [INSN_LEN-1:0] PAD_INSN = '0;
`endif

endpackage

// File: rtl/fetch_bundle_packer_bundle_fifo.sv
// bundle_fifo: synchronous FIFO of DEPTH entries holding packed fetch bundles.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_push, i_wdata   write request and entry (ignored when full or flushing)
//   i_pop             read request (ignored when empty or flushing)
//   i_flush           synchronous clear of both pointers, wins over push/pop
//   o_rdata           head entry (combinational read of the head slot)
//   o_full, o_empty   occupancy flags
//   o_level           entries held, 0..DEPTH
module bundle_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 131
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Extra MSB tells full (MSBs differ) from empty (pointers equal).
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  assign w_push = i_push && !o_full && !i_flush;
  assign w_pop  = i_pop && !o_empty && !i_flush;

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  // Pointer update; flush has priority over any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/fetch_bundle_packer.sv
// fetch_bundle_packer: packs 32-bit instruction words into 4-wide fetch bundles,
// buffers them in bundle_fifo and offers them to the pipeline under valid/ready.
// Build option: PACKER_NOP_PAD_EN selects NOP padding of short bundles (else zero).
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_insn       word input handshake
//   in_last                         closes the current bundle early
//   flush                           synchronous discard of all buffered state
//   out_valid/out_ready/out_idata   bundle output handshake, slot 0 in LSBs
//   out_count                       real instructions in the head bundle
//   level                           FIFO occupancy in bundles
module fetch_bundle_packer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned INSN_LEN = fetch_bundle_packer_pkg::INSN_LEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSN_LEN-1:0]      in_insn,
  input  logic                     in_last,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4*INSN_LEN-1:0]    out_idata,
  output logic [2:0]               out_count,
  output logic [$clog2(DEPTH):0]   level
);

  import fetch_bundle_packer_pkg::*;

  localparam int unsigned BUNDLE_W = ISSUE_WIDTH * INSN_LEN;
  localparam int unsigned ENTRY_W  = BUNDLE_W + CNT_W;

  typedef struct packed {
    logic [CNT_W-1:0]    count;
    logic [BUNDLE_W-1:0] idata;
  } bundle_t;

  logic [INSN_LEN-1:0] r_slot [ISSUE_WIDTH];
  logic [1:0]          r_fill;

  logic    w_full;
  logic    w_empty;
  logic    w_accept;
  logic    w_complete;
  logic    w_pop;
  bundle_t w_push_data;
  bundle_t w_head;

  // A pop in the same cycle never frees room for a push.
  assign in_ready   = !w_full && !flush;
  assign w_accept   = in_valid && in_ready;
  assign w_complete = w_accept && ((r_fill == 2'd3) || in_last);
  assign w_pop      = out_valid && out_ready;

  // Bundle image: held slots, then the incoming word, then pad.
  always_comb begin
    w_push_data       = '0;
    w_push_data.count = CNT_W'(r_fill) + CNT_W'(1);
    for (int i = 0; i < int'(ISSUE_WIDTH); i++) begin
      if (2'(i) < r_fill) begin
        w_push_data.idata[i*INSN_LEN +: INSN_LEN] = r_slot[i];
      end else if (2'(i) == r_fill) begin
        w_push_data.idata[i*INSN_LEN +: INSN_LEN] = in_insn;
      end else begin
        w_push_data.idata[i*INSN_LEN +: INSN_LEN] = INSN_LEN'(PAD_INSN);
      end
    end
  end

  // Pack register: store each accepted word, wrap fill on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fill <= 2'd0;
      for (int i = 0; i < int'(ISSUE_WIDTH); i++) r_slot[i] <= '0;
    end else if (flush) begin
      r_fill <= 2'd0;
    end else if (w_accept) begin
      r_slot[r_fill] <= in_insn;
      r_fill         <= w_complete ? 2'd0 : r_fill + 2'd1;
    end
  end

  bundle_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_bundle_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_complete),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_wdata (w_push_data),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign out_valid = !w_empty;
  assign out_idata = w_head.idata;
  assign out_count = w_head.count;

endmodule

// File: tb/tb_fetch_bundle_packer.sv
// Self-checking bench for fetch_bundle_packer against a queue-based bundle model.
module tb_fetch_bundle_packer;

  localparam int unsigned DEPTH = 4;

`ifdef PACKER_NOP_PAD_EN
  localparam logic [31:0] PAD = 32'h0000_0013;
`else
  localparam logic [31:0] PAD = 32'h0000_0000;
`endif

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_insn;
  logic         in_last;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_idata;
  logic [2:0]   out_count;
  logic [2:0]   level;

  int errors = 0;
  int checks = 0;

  // Model: completed bundles {count, idata} in order, plus words of the open bundle.
  logic [130:0] bundle_q[$];
  logic [31:0]  cur_q[$];

  fetch_bundle_packer #(.DEPTH(DEPTH), .INSN_LEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_insn   (in_insn),
    .in_last   (in_last),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idata (out_idata),
    .out_count (out_count),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_ready();
    return !flush && (bundle_q.size() < int'(DEPTH));
  endfunction

  function automatic logic [130:0] head_exp();
    return (bundle_q.size() != 0) ? bundle_q[0] : 131'd0;
  endfunction

  // Drive one cycle of stimulus, then advance the model past the rising edge.
  task automatic drive(input logic v, input logic [31:0] insn, input logic last,
                       input logic ordy, input logic fl);
    logic         acc;
    logic         pp;
    logic [127:0] b;
    @(negedge clk);
    in_valid  = v;
    in_insn   = insn;
    in_last   = last;
    out_ready = ordy;
    flush     = fl;
    acc = v && !fl && (bundle_q.size() < int'(DEPTH));
    pp  = ordy && !fl && (bundle_q.size() != 0);
    @(posedge clk);
    #1;
    if (fl) begin
      bundle_q.delete();
      cur_q.delete();
    end else begin
      if (pp) void'(bundle_q.pop_front());
      if (acc) begin
        cur_q.push_back(insn);
        if (cur_q.size() == 4 || last) begin
          b = '0;
          for (int i = 0; i < 4; i++) b[32*i +: 32] = (i < cur_q.size()) ? cur_q[i] : PAD;
          bundle_q.push_back({3'(cur_q.size()), b});
          cur_q.delete();
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_insn = '0; in_last = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0 || out_count !== 3'd0 || out_idata !== 128'd0) begin
      errors++;
      $display("FAIL reset_values valid=%0b level=%0d count=%0d idata=%h, required 0/0/0/0",
               out_valid, level, out_count, out_idata);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%0b required=1", in_ready);
    end
  endtask

  task automatic test_full_bundle();
    drive(1'b1, 32'h11, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'h22, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'h33, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'h44, 1'b0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_count !== 3'd4 ||
        out_idata !== 128'h00000044_00000033_00000022_00000011) begin
      errors++;
      $display("FAIL full_bundle valid=%0b count=%0d idata=%h, required 1/4/00000044000000330000002200000011",
               out_valid, out_count, out_idata);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL full_bundle_pop valid=%0b level=%0d required 0/0", out_valid, level);
    end
  endtask

  task automatic test_short_bundle();
    logic [127:0] exp;
    exp = {PAD, PAD, 32'hB, 32'hA};
    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 1'b1, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_count !== 3'd2 || out_idata !== exp) begin
      errors++;
      $display("FAIL short_bundle valid=%0b count=%0d idata=%h required 1/2/%h",
               out_valid, out_count, out_idata, exp);
    end
    // in_last on a word that is not accepted must not close a bundle.
    drive(1'b0, 32'hC, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 32'hD, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hE, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL ignored_last valid=%0b level=%0d required 0/0", out_valid, level);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4 * int'(DEPTH); i++)
      drive(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0, 1'b0);
    checks++;
    if (level !== 3'(DEPTH) || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_full level=%0d in_ready=%0b required %0d/0", level, in_ready, DEPTH);
    end
    for (int k = 0; k < int'(DEPTH); k++) begin
      checks++;
      if (out_valid !== 1'b1 || {out_count, out_idata} !== head_exp() ||
          out_idata[31:0] !== 32'h1000 + 32'(4*k)) begin
        errors++;
        $display("FAIL drain_order k=%0d got=%h required=%h", k, {out_count, out_idata}, head_exp());
      end
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      if (k == 0) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL drain_in_ready got=%0b required=1", in_ready);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL drain_empty valid=%0b level=%0d required 0/0", out_valid, level);
    end
  endtask

  task automatic test_random_stall();
    logic v;
    logic l;
    logic r;
    int   pops = 0;
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 4) == 0);
      r = (c % 64 < 20) ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (r && bundle_q.size() != 0) pops++;
      drive(v, $urandom, l, r, 1'b0);
      checks++;
      if (out_valid !== (bundle_q.size() != 0) || level !== 3'(bundle_q.size()) ||
          in_ready !== exp_ready()) begin
        errors++;
        $display("FAIL random_flags cyc=%0d valid=%0b level=%0d rdy=%0b required %0b/%0d/%0b",
                 c, out_valid, level, in_ready, bundle_q.size() != 0, bundle_q.size(), exp_ready());
      end
      if (bundle_q.size() != 0) begin
        checks++;
        if ({out_count, out_idata} !== head_exp()) begin
          errors++;
          $display("FAIL random_head cyc=%0d got=%h required=%h", c, {out_count, out_idata}, head_exp());
        end
      end
    end
    checks++;
    if (pops <= 2 * int'(DEPTH)) begin
      errors++;
      $display("FAIL random_wrap pops=%0d required more than %0d", pops, 2 * DEPTH);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 10; i++) drive(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0, 1'b0);
    checks++;
    if (level !== 3'd2) begin
      errors++;
      $display("FAIL flush_setup level=%0d required=2", level);
    end
    drive(1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL flush_clear valid=%0b level=%0d required 0/0", out_valid, level);
    end
    for (int i = 1; i <= 4; i++) drive(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || level !== 3'd1 || out_count !== 3'd4 ||
        out_idata !== 128'h00000504_00000503_00000502_00000501) begin
      errors++;
      $display("FAIL flush_fresh valid=%0b level=%0d count=%0d idata=%h required 1/1/4/00000504000005030000050200000501",
               out_valid, level, out_count, out_idata);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 14; i++) drive(1'b1, 32'h700 + 32'(i), 1'b0, 1'b0, 1'b0);
    checks++;
    if (level !== 3'd3) begin
      errors++;
      $display("FAIL areset_setup level=%0d required=3", level);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0 || out_count !== 3'd0 || out_idata !== 128'd0) begin
      errors++;
      $display("FAIL areset_immediate valid=%0b level=%0d count=%0d idata=%h required 0/0/0/0",
               out_valid, level, out_count, out_idata);
    end
    bundle_q.delete();
    cur_q.delete();
    @(negedge clk);
    reset = 1'b1;
    // Partial words from before reset must be gone.
    for (int i = 1; i <= 4; i++) drive(1'b1, 32'h900 + 32'(i), 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_idata !== 128'h00000904_00000903_00000902_00000901) begin
      errors++;
      $display("FAIL areset_fresh valid=%0b idata=%h required 1/00000904000009030000090200000901",
               out_valid, out_idata);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full_bundle();
    test_short_bundle();
    test_fill_drain();
    test_random_stall();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_bundle_packer.md
# fetch_bundle_packer

Transmit side of the core's 4-wide instruction-fetch interface. It accepts a stream of 32-bit instruction words from the fuzz/stimulus driver and packs them into 128-bit fetch bundles of four instructions. Bundles are buffered in a small FIFO and presented to the pipeline's `idata` input under a valid/ready handshake. It sits between the stimulus source and `pipeline`, replacing the free-running per-cycle `idata` register with a flow-controlled producer.

## Interface
Parameters:
- `DEPTH`, default 4: bundle FIFO entries; power of two, at least 2.
- `INSN_LEN`, default 32: instruction width, taken from the shared constants.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_insn` holds a word.
- `in_ready`  out  1  packer accepts a word this cycle.
- `in_insn`  in  INSN_LEN  instruction word.
- `in_last`  in  1  with an accepted word, closes the current bundle early.
- `flush`  in  1  synchronous discard of all buffered state (pipeline redirect).
- `out_valid`  out  1  `out_idata` holds a bundle.
- `out_ready`  in  1  pipeline consumes the bundle.
- `out_idata`  out  4*INSN_LEN  bundle; slot i is bits [INSN_LEN*i+INSN_LEN-1 : INSN_LEN*i]; slot 0 is the oldest word.
- `out_count`  out  3  number of real instructions in the bundle, 1..4.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy in bundles.

## Operation
- Pack register: 4 slots plus a 2-bit fill index (0..3).
- A word is accepted on `in_valid && in_ready`. It is written to slot[fill].
- The word completes the bundle when `fill==3` or `in_last`. On completion:
  - slot contents, word, and count go to the FIFO tail;
  - unfilled slots are set to the pad word;
  - `out_count = fill+1`;
  - fill resets to 0.
- Otherwise fill increments.
- `in_ready = !fifo_full && !flush`. A pop in the same cycle does not create room for a push when the FIFO is full.
- Pop on `out_valid && out_ready`.
- `out_idata` and `out_count` come from the FIFO head. They must stay stable while `out_valid && !out_ready`.
- Simultaneous push and pop with the FIFO neither empty nor full: `level` is unchanged.
- `flush` (highest priority, synchronous): clears FIFO pointers and fill. Any word presented that cycle is dropped. No pop occurs. The next cycle has `out_valid=0` and `level=0`.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.

## Timing
- Reset values: `out_valid=0`, `out_idata=0`, `out_count=0`, `level=0`, fill=0. `in_ready=1` from the first cycle after reset deasserts.
- Latency: completing word accepted in cycle N, with the FIFO empty, gives `out_valid=1` in cycle N+1 with that bundle.
- Throughput: one word per cycle in, one bundle per cycle out.
- Reset asserted mid-operation: all state cleared immediately. Partially packed words are lost.
- `in_last` with `fill==3` behaves identically to a normal fourth word.
- `in_last` is ignored when the word is not accepted.

## Configuration
- `PACKER_NOP_PAD_EN` defined: pad slots are `32'h00000013` (addi x0,x0,0).
- `PACKER_NOP_PAD_EN` undefined: pad slots are `32'h00000000`.
- `out_count` behaves the same in both builds.

## Structure
- Shared constants package: `INSN_LEN`, `ISSUE_WIDTH=4`, and the `NOP_INSN` encoding.
- One sub-module, `bundle_fifo`:
  - synchronous FIFO of DEPTH entries, each 4*INSN_LEN+3 bits;
  - push, pop, flush, full, empty, level.
- Pack register and handshake logic stay in `fetch_bundle_packer`.

## Test plan
- Reset, then words 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `out_ready=1` -> one cycle after 0x44, `out_valid=1`, `out_idata=128'h00000044_00000033_00000022_00000011`, `out_count=4`.
- Words 0xA, 0xB with `in_last` on 0xB, built with `PACKER_NOP_PAD_EN` -> `out_count=2`, slots 2 and 3 equal `0x00000013`. Without the macro, slots 2 and 3 equal 0.
- `out_ready=0`, stream 4*DEPTH words -> `level` reaches DEPTH and `in_ready=0`. Then raise `out_ready` -> DEPTH bundles come out in order, `in_ready` returns to 1 one cycle after the first pop.
- Random stall patterns on `out_ready` -> `out_idata` stays stable whenever `out_valid && !out_ready`; bundles are neither lost nor duplicated over pointer wrap (more than 2*DEPTH bundles).
- With 2 bundles queued and fill=2, assert `flush` together with `in_valid` -> next cycle `out_valid=0` and `level=0`. The next 4 words form a fresh bundle with no old words.
- Drop `reset` low mid-stream with `level=3` -> outputs immediately go to their reset values, without waiting for a clock edge.
